usb_frame_arbiter: RTL

- Shares the single USB output byte stream (data_o/valid_o/frame_o) between NB_SRC frame producers, e.g. several ble_packet_analyzer instances on different channel groups.
- Grants whole frames round-robin, never interleaving bytes of two frames.
- Enforces a maximum frame length and a minimum inter-frame gap.
- Sits between the analyzer outputs and the USB interface; the existing usb_itf monitor observes its output unchanged.

---
 rtl/usb_arb_pkg.sv | 29 ++
 rtl/usb_frame_arbiter_rr_picker.sv | 20 ++
 rtl/usb_frame_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/usb_arb_pkg.sv
// Shared types and the round-robin search used by the USB frame arbiter.
package usb_arb_pkg;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, GAP} arb_state_t;

  localparam int NB_SRC_MAX = 8;
  localparam int GRANT_W    = $clog2(NB_SRC_MAX);

  // First set bit of req after grant, wrapping modulo n; returns grant when req is empty.
  function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0]    grant,
                                                 input logic [NB_SRC_MAX-1:0] req,
                                                 input int unsigned           n);
    logic [GRANT_W-1:0] r_pick;
    logic [GRANT_W:0]   sum;
    logic               hit;
    r_pick = grant;
    hit    = 1'b0;
    for (int unsigned i = 1; i <= NB_SRC_MAX; i++) begin
      sum = {1'b0, grant} + (GRANT_W+1)'(i);
      if (32'(sum) >= n) sum = sum - (GRANT_W+1)'(n);
      if (i <= n && !hit && req[sum[GRANT_W-1:0]]) begin
        r_pick = sum[GRANT_W-1:0];
        hit    = 1'b1;
      end
    end
    return r_pick;
  endfunction

endpackage

// File: rtl/usb_frame_arbiter_rr_picker.sv
// Combinational round-robin priority search: lowest priority goes to the last grant.
module rr_picker
  import usb_arb_pkg::*;
#(
  parameter int NB_SRC = 4,
  parameter int GW     = $clog2(NB_SRC)
) (
  input  logic [NB_SRC-1:0] i_req,
  input  logic [GW-1:0]     i_last,
  output logic [GW-1:0]     o_idx,
  output logic              o_found
);

  logic [NB_SRC_MAX-1:0] w_req;

  assign w_req   = NB_SRC_MAX'(i_req);
  assign o_idx   = GW'(rr_next(GRANT_W'(i_last), w_req, NB_SRC));
  assign o_found = |i_req;

endmodule

// File: rtl/usb_frame_arbiter.sv
// Shares one USB byte stream between NB_SRC frame producers, granting whole frames
// round-robin with a length limit and a forced inter-frame gap.
//
//   state | meaning
//   IDLE  | no frame owned; search requesters starting after the last grant
//   XFER  | forwarding the granted source's bytes, frame_o high
//   DRAIN | frame truncated; swallow the rest of it with ready held high
//   GAP   | frame_o low for IDLE_GAP cycles before the next search
module usb_frame_arbiter
  import usb_arb_pkg::*;
#(
  parameter int NB_SRC        = 4,
  parameter int DATA_W        = 8,
  parameter int MAX_FRAME_LEN = 64,
  parameter int IDLE_GAP      = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NB_SRC*DATA_W-1:0]   src_data_i,
  input  logic [NB_SRC-1:0]          src_valid_i,
  input  logic [NB_SRC-1:0]          src_frame_i,
  output logic [NB_SRC-1:0]          src_ready_o,
  output logic [DATA_W-1:0]          data_o,
  output logic                       valid_o,
  output logic                       frame_o,
  output logic [$clog2(NB_SRC)-1:0]  grant_o,
  output logic                       busy_o,
  output logic                       abort_o
);

  localparam int GW    = $clog2(NB_SRC);
  localparam int CNT_W = (IDLE_GAP > 255) ? $clog2(IDLE_GAP) + 1 : 8;

  arb_state_t        r_state, w_state_nxt;
  logic [GW-1:0]     r_grant, w_grant_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_frame, w_frame_nxt;
  logic              r_abort, w_abort_nxt;
  logic              r_busy, w_busy_nxt;

  logic [DATA_W-1:0] w_bytes [NB_SRC];
  logic [GW-1:0]     w_pick_idx;
  logic              w_pick_found;
  logic              w_gframe, w_gvalid, w_ready_en, w_acc;

  rr_picker #(.NB_SRC(NB_SRC), .GW(GW)) u_picker (
    .i_req   (src_frame_i),
    .i_last  (r_grant),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  always_comb begin
    for (int k = 0; k < NB_SRC; k++) w_bytes[k] = src_data_i[k*DATA_W +: DATA_W];
  end

  assign w_gframe   = src_frame_i[r_grant];
  assign w_gvalid   = src_valid_i[r_grant];
  assign w_ready_en = (r_state == XFER) || (r_state == DRAIN);
  assign w_acc      = w_ready_en & w_gframe & w_gvalid;

  // Ready follows the granted frame line so a byte offered as the frame ends is refused.
  always_comb begin
    src_ready_o = '0;
    if (w_ready_en) src_ready_o[r_grant] = w_gframe;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_frame_nxt = 1'b0;
    w_abort_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_found) begin
          w_grant_nxt = w_pick_idx;
          w_cnt_nxt   = '0;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        if (!w_gframe) begin
          w_cnt_nxt   = '0;
          w_state_nxt = GAP;
        end else if (w_acc && r_cnt == CNT_W'(MAX_FRAME_LEN)) begin
          w_abort_nxt = 1'b1;
          w_state_nxt = DRAIN;
        end else begin
          w_frame_nxt = 1'b1;
          w_data_nxt  = w_bytes[r_grant];
          w_valid_nxt = w_gvalid;
          if (w_acc) w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (!w_gframe) begin
          w_cnt_nxt   = '0;
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (r_cnt == CNT_W'(IDLE_GAP - 1)) w_state_nxt = IDLE;
        else                               w_cnt_nxt   = r_cnt + 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_grant <= GW'(NB_SRC - 1);
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_frame <= 1'b0;
      r_abort <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_frame <= w_frame_nxt;
      r_abort <= w_abort_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign frame_o = r_frame;
  assign grant_o = r_grant;
  assign busy_o  = r_busy;
  assign abort_o = r_abort;

endmodule
